// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM pipeline stage.
//   - funct3 size/sign codes used by loads and stores
//   - 2-bit FSM state encoding for mem_access_stage
//   - watchdog counter width
//   - lane-mask, alignment and store-data helper functions
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_W = 8;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_READY = 2'd1;
    localparam logic [1:0] S_WAIT_RESP  = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    // Byte lanes touched by an access of the given size at the given offset.
    // Unknown funct3 codes are treated as full-word accesses.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = off[1] ? 4'b1100 : 4'b0011;
            default:     m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3)
            F3_H, F3_HU: r = off[0];
            F3_W:        r = (off != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Store data replicated across all lanes; the mask selects the live ones.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{rs2[7:0]}};
            F3_H:    d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data alignment.
//   i_funct3  load size/sign code
//   i_offset  byte offset within the word (addr[1:0])
//   i_raw     raw word returned by data memory
//   o_data    selected lane, sign- or zero-extended to 32 bits
//   o_mask    byte lanes covered by the access
module mem_load_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data,
    output logic [3:0]  o_mask
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_raw[7:0];
        case (i_offset)
            2'd0: byte_sel = i_raw[7:0];
            2'd1: byte_sel = i_raw[15:8];
            2'd2: byte_sel = i_raw[23:16];
            2'd3: byte_sel = i_raw[31:24];
            default: byte_sel = i_raw[7:0];
        endcase
        half_sel = i_offset[1] ? i_raw[31:16] : i_raw[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   o_data = {24'd0, byte_sel};
            F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   o_data = {16'd0, half_sel};
            default: o_data = i_raw;
        endcase
        o_mask = lane_mask(i_funct3, i_offset);
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage of the RV32I core.
// Turns load/store micro-ops into word-aligned requests on a req/ready,
// rvalid data bus, stalls the pipeline until the access completes, and
// presents aligned load data plus retire fields for the MEM/WB register.
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid .. i_rs2_rdata    EX/MEM slot contents
//   o_mem_* / i_mem_*         data-memory bus
//   o_stall                   freeze IF..EX/MEM and hold MEM/WB
//   o_load_data, o_dmem_*     retire results (non-zero only in DONE)
//   o_misaligned              misaligned access, no bus request
//   o_bus_err                 watchdog expiry pulse
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [3:0]  o_mem_wmask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_rdata,
    output logic [31:0] o_dmem_wdata,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam bit                WDOG_EN    = (MAX_WAIT != 0);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic memop, mis, start, in_wait, timeout, done;
    logic [31:0] align_data;
    logic [3:0]  align_mask;

    assign memop   = i_valid & (i_mem_read | i_mem_write);
    assign mis     = is_misaligned(i_funct3, i_alu_result[1:0]);
    assign start   = memop & ~mis;
    assign in_wait = (state_q == S_WAIT_READY) | (state_q == S_WAIT_RESP);
    assign timeout = WDOG_EN & in_wait & (cnt_q == MAX_WAIT_C);
    assign done    = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // EX/MEM is frozen from here on, so capturing once is enough.
                    addr_d  = i_alu_result;
                    f3_d    = i_funct3;
                    wen_d   = i_mem_write;
                    ren_d   = i_mem_read & ~i_mem_write;
                    wdata_d = i_mem_write ? store_wdata(i_funct3, i_rs2_rdata) : '0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (i_mem_ready) state_d = i_mem_write ? S_DONE : S_WAIT_RESP;
                    else             state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (timeout) begin
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (i_mem_ready) begin
                    cnt_d   = '0;
                    state_d = wen_q ? S_DONE : S_WAIT_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_RESP: begin
                if (timeout) begin
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (i_mem_rvalid) begin
                    rdata_d = i_mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mem_load_align u_align (
        .i_funct3 (f3_q),
        .i_offset (addr_q[1:0]),
        .i_raw    (rdata_q),
        .o_data   (align_data),
        .o_mask   (align_mask)
    );

    // The IDLE-state decode reads live EX/MEM inputs, so it is qualified with
    // reset to keep the bus and pipeline quiet while reset is held.
    assign o_mem_req    = i_rst_n & (((state_q == S_IDLE) & start) | (state_q == S_WAIT_READY));
    assign o_stall      = i_rst_n & (((state_q == S_IDLE) & start) | in_wait);
    assign o_misaligned = i_rst_n & (state_q == S_IDLE) & memop & mis;
    assign o_bus_err    = timeout;

    assign o_mem_addr  = {i_alu_result[31:2], 2'b00};
    assign o_mem_wen   = i_mem_write;
    assign o_mem_wmask = i_mem_write ? lane_mask(i_funct3, i_alu_result[1:0]) : 4'b0000;
    assign o_mem_wdata = store_wdata(i_funct3, i_rs2_rdata);

    assign o_load_data  = (done & ren_q) ? align_data : '0;
    assign o_dmem_addr  = done ? addr_q : '0;
    assign o_dmem_mask  = done ? align_mask : 4'b0000;
    assign o_dmem_ren   = done & ren_q;
    assign o_dmem_wen   = done & wen_q;
    assign o_dmem_rdata = done ? rdata_q : '0;
    assign o_dmem_wdata = done ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, i_mem_read, i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result, i_rs2_rdata;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ready, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_stall, o_dmem_ren, o_dmem_wen, o_misaligned, o_bus_err;
    logic [31:0] o_load_data, o_dmem_addr, o_dmem_rdata, o_dmem_wdata;
    logic [3:0]  o_dmem_mask;

    always #5 i_clk = ~i_clk;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_funct3(i_funct3),
        .i_alu_result(i_alu_result), .i_rs2_rdata(i_rs2_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wmask(o_mem_wmask), .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_stall(o_stall), .o_load_data(o_load_data), .o_dmem_addr(o_dmem_addr),
        .o_dmem_mask(o_dmem_mask), .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen),
        .o_dmem_rdata(o_dmem_rdata), .o_dmem_wdata(o_dmem_wdata),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    int checks = 0;
    int errors = 0;

    // Observations of the most recent run_access call.
    int          r_stalls, r_reqs, r_err_cyc, r_err_cnt;
    logic        r_timeout, r_addr_stable, r_mis, r_wen;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] d_load, d_addr, d_rdata, d_wdata;
    logic [3:0]  d_mask;
    logic        d_ren, d_wen;

    // Presents one instruction, drives ready in cycle ready_cyc (relative to
    // the first cycle, -1 = never) and rvalid gap cycles after acceptance.
    // Records bus activity and the retire fields of the first non-stall cycle.
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input int ready_cyc, input int gap,
                              input logic [31:0] rdata);
        int  acc;
        bit  fin;
        acc = -1; fin = 0;
        r_stalls = 0; r_reqs = 0; r_err_cyc = -1; r_err_cnt = 0;
        r_addr_stable = 1'b1; r_mis = 1'b0; r_wen = 1'b0;
        r_addr = '0; r_wdata = '0; r_wmask = '0;
        i_valid = 1'b1; i_mem_read = ~wr; i_mem_write = wr; i_funct3 = f3;
        i_alu_result = addr; i_rs2_rdata = rs2; i_mem_rdata = rdata;
        for (int c = 0; c < 20; c++) begin
            i_mem_ready  = (c == ready_cyc);
            i_mem_rvalid = (acc >= 0) && (c == acc + gap);
            #1;
            if (o_bus_err) begin
                if (r_err_cnt == 0) r_err_cyc = c;
                r_err_cnt++;
            end
            if (o_misaligned) r_mis = 1'b1;
            if (o_mem_req) begin
                if (r_reqs == 0) begin
                    r_addr = o_mem_addr; r_wmask = o_mem_wmask; r_wdata = o_mem_wdata; r_wen = o_mem_wen;
                end else if (o_mem_addr !== r_addr) begin
                    r_addr_stable = 1'b0;
                end
                r_reqs++;
                if (i_mem_ready) acc = c;
            end
            if (!o_stall) begin
                d_load = o_load_data; d_addr = o_dmem_addr; d_mask = o_dmem_mask;
                d_ren = o_dmem_ren; d_wen = o_dmem_wen; d_rdata = o_dmem_rdata; d_wdata = o_dmem_wdata;
                fin = 1;
                break;
            end
            r_stalls++;
            @(posedge i_clk); #1;
        end
        r_timeout = !fin;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = F3_W;
        i_alu_result = 32'h40; i_rs2_rdata = '0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        #3;
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", o_mem_req); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", o_stall); end
        checks++; if (o_load_data !== 32'h0) begin errors++; $display("FAIL reset_load got %h exp 0", o_load_data); end
        checks++; if ({o_dmem_ren, o_dmem_wen, o_bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {o_dmem_ren, o_dmem_wen, o_bus_err}); end
        i_alu_result = 32'h41;
        #1;
        checks++; if (o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", o_misaligned); end
        i_valid = 1'b0; i_mem_read = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", o_stall); end
    endtask

    task automatic test_sw();
        run_access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL sw_done got timeout exp completion"); end
        checks++; if (r_stalls !== 1) begin errors++; $display("FAIL sw_stalls got %0d exp 1", r_stalls); end
        checks++; if (r_reqs !== 1) begin errors++; $display("FAIL sw_reqs got %0d exp 1", r_reqs); end
        checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp 00000100", r_addr); end
        checks++; if (r_wmask !== 4'b1111) begin errors++; $display("FAIL sw_wmask got %b exp 1111", r_wmask); end
        checks++; if (r_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", r_wdata); end
        checks++; if (r_wen !== 1'b1) begin errors++; $display("FAIL sw_wen got %b exp 1", r_wen); end
        checks++; if ({d_wen, d_ren} !== 2'b10) begin errors++; $display("FAIL sw_retire got wen,ren=%b exp 10", {d_wen, d_ren}); end
        checks++; if (d_mask !== 4'b1111) begin errors++; $display("FAIL sw_dmask got %b exp 1111", d_mask); end
        checks++; if (d_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dwdata got %h exp deadbeef", d_wdata); end
        checks++; if (d_addr !== 32'h100) begin errors++; $display("FAIL sw_daddr got %h exp 00000100", d_addr); end
    endtask

    task automatic test_sb_wait();
        run_access(1'b1, F3_B, 32'h203, 32'h000000A5, 3, 0, 32'h0);
        checks++; if (r_stalls !== 4) begin errors++; $display("FAIL sb_stalls got %0d exp 4", r_stalls); end
        checks++; if (r_reqs !== 4) begin errors++; $display("FAIL sb_reqs got %0d exp 4", r_reqs); end
        checks++; if (r_addr_stable !== 1'b1) begin errors++; $display("FAIL sb_addr_hold got unstable exp stable"); end
        checks++; if (r_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got %h exp 00000200", r_addr); end
        checks++; if (r_wmask !== 4'b1000) begin errors++; $display("FAIL sb_wmask got %b exp 1000", r_wmask); end
        checks++; if (r_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", r_wdata); end
        checks++; if (d_wen !== 1'b1) begin errors++; $display("FAIL sb_dwen got %b exp 1", d_wen); end
        checks++; if (d_addr !== 32'h203) begin errors++; $display("FAIL sb_daddr got %h exp 00000203", d_addr); end
        checks++; if (d_mask !== 4'b1000) begin errors++; $display("FAIL sb_dmask got %b exp 1000", d_mask); end
        checks++; if (r_err_cnt !== 0) begin errors++; $display("FAIL sb_buserr got %0d exp 0", r_err_cnt); end
    endtask

    task automatic test_loads();
        run_access(1'b0, F3_B, 32'h102, 32'h0, 0, 2, 32'h0080FF11);
        checks++; if (r_stalls !== 3) begin errors++; $display("FAIL lb_stalls got %0d exp 3", r_stalls); end
        checks++; if (d_load !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", d_load); end
        checks++; if ({d_ren, d_wen} !== 2'b10) begin errors++; $display("FAIL lb_retire got ren,wen=%b exp 10", {d_ren, d_wen}); end
        checks++; if (d_mask !== 4'b0100) begin errors++; $display("FAIL lb_mask got %b exp 0100", d_mask); end
        checks++; if (d_rdata !== 32'h0080FF11) begin errors++; $display("FAIL lb_raw got %h exp 0080ff11", d_rdata); end
        checks++; if (r_addr !== 32'h100 || r_wen !== 1'b0) begin errors++; $display("FAIL lb_req got addr %h wen %b exp 00000100 0", r_addr, r_wen); end
        run_access(1'b0, F3_BU, 32'h102, 32'h0, 0, 2, 32'h0080FF11);
        checks++; if (d_load !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", d_load); end
        run_access(1'b0, F3_HU, 32'h102, 32'h0, 0, 2, 32'h0080FF11);
        checks++; if (d_load !== 32'h00000080) begin errors++; $display("FAIL lhu_data got %h exp 00000080", d_load); end
        checks++; if (d_mask !== 4'b1100) begin errors++; $display("FAIL lhu_mask got %b exp 1100", d_mask); end
        run_access(1'b0, F3_H, 32'h100, 32'h0, 0, 1, 32'h0080FF11);
        checks++; if (r_stalls !== 2) begin errors++; $display("FAIL lh_stalls got %0d exp 2", r_stalls); end
        checks++; if (d_load !== 32'hFFFFFF11) begin errors++; $display("FAIL lh_data got %h exp ffffff11", d_load); end
        checks++; if (d_mask !== 4'b0011) begin errors++; $display("FAIL lh_mask got %b exp 0011", d_mask); end
        run_access(1'b0, F3_W, 32'h104, 32'h0, 2, 1, 32'hCAFEF00D);
        checks++; if (r_stalls !== 4) begin errors++; $display("FAIL lw_wait_stalls got %0d exp 4", r_stalls); end
        checks++; if (d_load !== 32'hCAFEF00D) begin errors++; $display("FAIL lw_wait_data got %h exp cafef00d", d_load); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, F3_W, 32'h101, 32'h0, 0, 1, 32'h11111111);
        checks++; if (r_mis !== 1'b1) begin errors++; $display("FAIL lw_mis_flag got %b exp 1", r_mis); end
        checks++; if (r_reqs !== 0) begin errors++; $display("FAIL lw_mis_reqs got %0d exp 0", r_reqs); end
        checks++; if (r_stalls !== 0) begin errors++; $display("FAIL lw_mis_stalls got %0d exp 0", r_stalls); end
        checks++; if ({d_ren, d_wen} !== 2'b00) begin errors++; $display("FAIL lw_mis_retire got %b exp 00", {d_ren, d_wen}); end
        run_access(1'b1, F3_H, 32'h103, 32'h1234, 0, 0, 32'h0);
        checks++; if (r_mis !== 1'b1 || r_reqs !== 0) begin errors++; $display("FAIL sh_mis got mis %b reqs %0d exp 1 0", r_mis, r_reqs); end
        checks++; if (d_wen !== 1'b0) begin errors++; $display("FAIL sh_mis_wen got %b exp 0", d_wen); end
    endtask

    task automatic test_timeout();
        run_access(1'b0, F3_W, 32'h300, 32'h0, -1, 1, 32'h55555555);
        checks++; if (r_err_cyc !== 5) begin errors++; $display("FAIL wdog_ready_cycle got %0d exp 5", r_err_cyc); end
        checks++; if (r_err_cnt !== 1) begin errors++; $display("FAIL wdog_ready_pulses got %0d exp 1", r_err_cnt); end
        checks++; if (r_stalls !== 6) begin errors++; $display("FAIL wdog_ready_stalls got %0d exp 6", r_stalls); end
        checks++; if (d_load !== 32'h0) begin errors++; $display("FAIL wdog_ready_data got %h exp 0", d_load); end
        checks++; if (r_mis !== 1'b0) begin errors++; $display("FAIL wdog_mis got %b exp 0", r_mis); end
        #1;
        checks++; if ({o_stall, o_bus_err} !== 2'b00) begin errors++; $display("FAIL wdog_idle got %b exp 00", {o_stall, o_bus_err}); end
        run_access(1'b0, F3_W, 32'h304, 32'h0, 0, 99, 32'h55555555);
        checks++; if (r_err_cyc !== 5) begin errors++; $display("FAIL wdog_resp_cycle got %0d exp 5", r_err_cyc); end
        checks++; if (d_load !== 32'h0) begin errors++; $display("FAIL wdog_resp_data got %h exp 0", d_load); end
    endtask

    task automatic test_reset_mid();
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = F3_W;
        i_alu_result = 32'h400; i_mem_ready = 1'b1; i_mem_rvalid = 1'b0;
        @(posedge i_clk); #1;
        i_mem_ready = 1'b0;
        #1;
        checks++; if ({o_stall, o_mem_req} !== 2'b10) begin errors++; $display("FAIL mid_wait_resp got stall,req=%b exp 10", {o_stall, o_mem_req}); end
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_stall, o_mem_req} !== 2'b00) begin errors++; $display("FAIL mid_reset got stall,req=%b exp 00", {o_stall, o_mem_req}); end
        i_valid = 1'b0; i_mem_read = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        #1;
        checks++; if ({o_stall, o_dmem_ren} !== 2'b00 || o_load_data !== 32'h0) begin errors++; $display("FAIL late_rvalid got stall,ren=%b data %h exp 00 0", {o_stall, o_dmem_ren}, o_load_data); end
        run_access(1'b0, F3_W, 32'h404, 32'h0, 0, 1, 32'h12345678);
        checks++; if (r_stalls !== 2) begin errors++; $display("FAIL post_reset_stalls got %0d exp 2", r_stalls); end
        checks++; if (d_load !== 32'h12345678) begin errors++; $display("FAIL post_reset_data got %h exp 12345678", d_load); end
        checks++; if (d_addr !== 32'h404 || d_mask !== 4'b1111) begin errors++; $display("FAIL post_reset_retire got %h %b exp 00000404 1111", d_addr, d_mask); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_wait();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
